// File: rtl/as512512512_uart_fifo.sv
// Full-duplex UART with configurable data/stop bits, glitch-filtered mid-bit RX and an RX FIFO.
// Parity support is compiled in only when AS512512512_UART_PARITY_EN is defined.
module as512512512_uart_fifo #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned RX_DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               divisor,
    input  logic [DATA_BITS-1:0]      din,
    input  logic                      start,
    output logic                      busy,
    output logic                      TX,
    input  logic                      RX,
    output logic [DATA_BITS-1:0]      dout,
    output logic                      has_byte,
    input  logic                      rd,
    output logic [$clog2(RX_DEPTH):0] rx_count,
    output logic                      overrun,
    output logic                      frame_err,
    input  logic                      clr_err,
    input  logic                      parity_en,
    input  logic                      parity_odd,
    output logic                      parity_err
);
    localparam int unsigned AW = $clog2(RX_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [3:0] LAST_IDX = 4'(DATA_BITS - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(RX_DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitHi} state_e;

    state_e               tx_state;
    logic [15:0]          tx_cnt;
    logic [15:0]          tx_div;
    logic [DATA_BITS-1:0] tx_shift;
    logic [3:0]           tx_idx;
    logic                 tx_stop_idx;

    state_e               rx_state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [15:0]          rx_cnt;
    logic [15:0]          rx_div;
    logic [DATA_BITS-1:0] rx_shift;
    logic [3:0]           rx_idx;
    logic                 rx_push;
    logic                 rx_frame_set;

    logic [DATA_BITS-1:0] mem [RX_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 full;
    logic                 do_push;
    logic                 do_pop;

`ifdef AS512512512_UART_PARITY_EN
    logic tx_par_on;
    logic tx_par;
    logic rx_par_on;
    logic rx_par_odd;
    logic rx_par_bad;
    logic rx_par_set;
`else
    logic unused_parity;
    assign unused_parity = parity_en ^ parity_odd;
    assign parity_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state    <= StIdle;
            tx_cnt      <= '0;
            tx_div      <= '0;
            tx_shift    <= '0;
            tx_idx      <= '0;
            tx_stop_idx <= 1'b0;
            busy        <= 1'b0;
            TX          <= 1'b1;
`ifdef AS512512512_UART_PARITY_EN
            tx_par_on   <= 1'b0;
            tx_par      <= 1'b0;
`endif
        end else begin
            unique case (tx_state)
                StIdle: begin
                    TX   <= 1'b1;
                    busy <= 1'b0;
                    if (start) begin
                        tx_state <= StStart;
                        tx_div   <= divisor;
                        tx_shift <= din;
                        tx_cnt   <= '0;
                        busy     <= 1'b1;
                        TX       <= 1'b0;
`ifdef AS512512512_UART_PARITY_EN
                        tx_par_on <= parity_en;
                        tx_par    <= (^din) ^ parity_odd;
`endif
                    end
                end
                StStart: begin
                    if (tx_cnt == tx_div) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        TX       <= tx_shift[0];
                        tx_state <= StData;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                StData: begin
                    if (tx_cnt == tx_div) begin
                        tx_cnt <= '0;
                        if (tx_idx == LAST_IDX) begin
                            TX          <= 1'b1;
                            tx_stop_idx <= 1'b0;
                            tx_state    <= StStop;
`ifdef AS512512512_UART_PARITY_EN
                            if (tx_par_on) begin
                                TX       <= tx_par;
                                tx_state <= StParity;
                            end
`endif
                        end else begin
                            tx_idx   <= tx_idx + 4'd1;
                            tx_shift <= tx_shift >> 1;
                            TX       <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                StParity: begin
                    if (tx_cnt == tx_div) begin
                        tx_cnt      <= '0;
                        TX          <= 1'b1;
                        tx_stop_idx <= 1'b0;
                        tx_state    <= StStop;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                StStop: begin
                    if (tx_cnt == tx_div) begin
                        tx_cnt <= '0;
                        if (STOP_BITS == 1 || tx_stop_idx) begin
                            busy     <= 1'b0;
                            tx_state <= StIdle;
                        end else begin
                            tx_stop_idx <= 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                default: tx_state <= StIdle;
            endcase
        end
    end

    // Samples are taken divisor+1 clocks apart, starting at the start-bit midpoint.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            rx_state     <= StIdle;
            rx_cnt       <= '0;
            rx_div       <= '0;
            rx_shift     <= '0;
            rx_idx       <= '0;
            rx_push      <= 1'b0;
            rx_frame_set <= 1'b0;
`ifdef AS512512512_UART_PARITY_EN
            rx_par_on    <= 1'b0;
            rx_par_odd   <= 1'b0;
            rx_par_bad   <= 1'b0;
            rx_par_set   <= 1'b0;
`endif
        end else begin
            rx_meta      <= RX;
            rx_s         <= rx_meta;
            rx_push      <= 1'b0;
            rx_frame_set <= 1'b0;
`ifdef AS512512512_UART_PARITY_EN
            rx_par_set   <= 1'b0;
`endif
            unique case (rx_state)
                StIdle: begin
                    if (!rx_s) begin
                        rx_state <= StStart;
                        rx_cnt   <= '0;
                        rx_div   <= divisor;
`ifdef AS512512512_UART_PARITY_EN
                        rx_par_on  <= parity_en;
                        rx_par_odd <= parity_odd;
                        rx_par_bad <= 1'b0;
`endif
                    end
                end
                StStart: begin
                    if (rx_cnt == (rx_div >> 1)) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_s ? StIdle : StData;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                StData: begin
                    if (rx_cnt == rx_div) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                        if (rx_idx == LAST_IDX) begin
                            rx_state <= StStop;
`ifdef AS512512512_UART_PARITY_EN
                            if (rx_par_on) rx_state <= StParity;
`endif
                        end else begin
                            rx_idx <= rx_idx + 4'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                StParity: begin
                    if (rx_cnt == rx_div) begin
                        rx_cnt   <= '0;
                        rx_state <= StStop;
`ifdef AS512512512_UART_PARITY_EN
                        rx_par_bad <= rx_s ^ (^rx_shift) ^ rx_par_odd;
`endif
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                StStop: begin
                    if (rx_cnt == rx_div) begin
                        rx_cnt <= '0;
                        if (rx_s) begin
                            rx_push  <= 1'b1;
                            rx_state <= StIdle;
`ifdef AS512512512_UART_PARITY_EN
                            rx_par_set <= rx_par_bad;
`endif
                        end else begin
                            rx_frame_set <= 1'b1;
                            rx_state     <= StWaitHi;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                StWaitHi: begin
                    // A held-low line (break) must not look like a new start bit.
                    if (rx_s) rx_state <= StIdle;
                end
                default: rx_state <= StIdle;
            endcase
        end
    end

    assign full     = (rx_count == FULL_CNT);
    assign do_pop   = rd && (rx_count != '0);
    assign do_push  = rx_push && (!full || do_pop);
    assign has_byte = (rx_count != '0);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rx_count  <= '0;
            dout      <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            rx_count <= rx_count + CW'(do_push) - CW'(do_pop);
            // dout is the registered head: refresh on pop, or when a push lands in an empty slot.
            if (do_pop && rx_count > CW'(1)) begin
                dout <= mem[rd_ptr + 1'b1];
            end else if (do_push && (rx_count == '0 || do_pop)) begin
                dout <= rx_shift;
            end
            overrun   <= (rx_push && !do_push) || (overrun && !clr_err);
            frame_err <= rx_frame_set || (frame_err && !clr_err);
        end
    end

`ifdef AS512512512_UART_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= rx_par_set || (parity_err && !clr_err);
        end
    end
`endif

endmodule
